// File: rtl/game_pkg.sv
// Shared screen geometry, enemy constants, colours and FSM encoding for the
// enemy side of the game.
package game_pkg;

    localparam int N_W      = 5;
    localparam int W_SIZE   = 16;
    localparam int R_SIZE   = 24;
    localparam int SPACING  = 96;
    localparam int H_START  = 144;
    localparam int H_END    = 784;
    localparam int V_START  = 31;
    localparam int V_END    = 511;
    localparam int FORM_X0  = 176;
    localparam int FORM_Y0  = 79;
    localparam int R_Y      = 39;
    localparam int DROP     = 8;
    localparam int BREACH_Y = 440;
    localparam int RESPAWN  = 120;

    localparam logic [7:0] RGB_WHITE = 8'hFF;
    localparam logic [7:0] RGB_RED   = 8'hE0;
    localparam logic [7:0] RGB_BLACK = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SPAWN,
        ST_MARCH,
        ST_CLEARED,
        ST_HALT
    } state_e;

    // Points for one cycle of kills: 1 per white, 3 for red, capped at 3.
    function automatic logic [1:0] kill_points(input logic [N_W-1:0] kills_w,
                                               input logic kill_r);
        int sum;
        sum = kill_r ? 3 : 0;
        for (int i = 0; i < N_W; i++) begin
            sum += int'(kills_w[i]);
        end
        return (sum > 3) ? 2'd3 : 2'(sum);
    endfunction

endpackage

// File: rtl/enemy_sprite_hit.sv
// Square sprite overlap test: is the scan pixel inside [pos, pos+size) on both
// axes of an active sprite.
module enemy_sprite_hit (
    input  logic [9:0]  x_i,
    input  logic [9:0]  y_i,
    input  logic [10:0] pos_x_i,
    input  logic [10:0] pos_y_i,
    input  logic [5:0]  size_i,
    input  logic        active_i,
    output logic        on_o
);

    logic [10:0] x_ext;
    logic [10:0] y_ext;
    logic [10:0] size_ext;

    assign x_ext    = {1'b0, x_i};
    assign y_ext    = {1'b0, y_i};
    assign size_ext = {5'b0, size_i};

    assign on_o = active_i
               && (x_ext >= pos_x_i) && (x_ext < pos_x_i + size_ext)
               && (y_ext >= pos_y_i) && (y_ext < pos_y_i + size_ext);

endmodule

// File: rtl/enemy_wave.sv
// Enemy wave controller: a marching five-enemy white formation plus a bouncing
// red enemy, with hit scoring, wave-clear and breach detection.
module enemy_wave
    import game_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           frame_tick,
    input  logic           pause,
    input  logic           game_start_on,
    input  logic           game_over_on,
    input  logic [9:0]     x,
    input  logic [9:0]     y,
    input  logic [N_W-1:0] hit_w_enemy,
    input  logic           hit_r_enemy,
    output logic [N_W-1:0] e_w_on,
    output logic           e_r_on,
    output logic [N_W-1:0] e_w_active,
    output logic           e_r_active,
    output logic [1:0]     score_pulse,
    output logic           wave_clear,
    output logic           breach,
    output logic [2:0]     wave_num,
    output logic [7:0]     rgb
);

    localparam logic [10:0] H_START_11   = 11'(H_START);
    localparam logic [10:0] H_END_11     = 11'(H_END);
    localparam logic [10:0] FORM_SPAN_11 = 11'((N_W - 1) * SPACING + W_SIZE);
    localparam logic [10:0] R_MAX_11     = 11'(H_END - R_SIZE);
    localparam logic [10:0] BREACH_Y_11  = 11'(BREACH_Y);
    localparam logic [10:0] W_SIZE_11    = 11'(W_SIZE);

    state_e         state_q, state_d;
    logic [N_W-1:0] ew_act_q, ew_act_d;
    logic           er_act_q, er_act_d;
    logic [9:0]     fx_q, fx_d;
    logic [9:0]     fy_q, fy_d;
    logic           dir_q, dir_d;       // 1 = moving left
    logic [9:0]     rx_q, rx_d;
    logic           rdir_q, rdir_d;     // 1 = moving left
    logic [6:0]     timer_q, timer_d;
    logic [2:0]     wave_q, wave_d;
    logic [1:0]     score_q, score_d;
    logic           clear_q, clear_d;
    logic           breach_q, breach_d;

    logic [N_W-1:0] kills_w;
    logic           kill_r;
    logic           move;
    logic [3:0]     step;
    logic [4:0]     rstep;

    assign kills_w = hit_w_enemy & ew_act_q;
    assign kill_r  = hit_r_enemy & er_act_q;
    assign move    = frame_tick & ~pause;
    assign step    = {1'b0, wave_q} + 4'd1;
    assign rstep   = {step, 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ew_act_q <= '0;
            er_act_q <= 1'b0;
            fx_q     <= 10'(FORM_X0);
            fy_q     <= 10'(FORM_Y0);
            dir_q    <= 1'b0;
            rx_q     <= 10'(H_START);
            rdir_q   <= 1'b0;
            timer_q  <= '0;
            wave_q   <= '0;
            score_q  <= '0;
            clear_q  <= 1'b0;
            breach_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ew_act_q <= ew_act_d;
            er_act_q <= er_act_d;
            fx_q     <= fx_d;
            fy_q     <= fy_d;
            dir_q    <= dir_d;
            rx_q     <= rx_d;
            rdir_q   <= rdir_d;
            timer_q  <= timer_d;
            wave_q   <= wave_d;
            score_q  <= score_d;
            clear_q  <= clear_d;
            breach_q <= breach_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ew_act_d = ew_act_q;
        er_act_d = er_act_q;
        fx_d     = fx_q;
        fy_d     = fy_q;
        dir_d    = dir_q;
        rx_d     = rx_q;
        rdir_d   = rdir_q;
        timer_d  = timer_q;
        wave_d   = wave_q;
        score_d  = '0;
        clear_d  = 1'b0;
        breach_d = 1'b0;

        if (game_over_on && (state_q != ST_IDLE)) begin
            state_d = ST_HALT;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (game_start_on) state_d = ST_SPAWN;
                end
                ST_SPAWN: begin
                    fx_d     = 10'(FORM_X0);
                    fy_d     = 10'(FORM_Y0);
                    dir_d    = 1'b0;
                    ew_act_d = '1;
                    er_act_d = 1'b1;
                    rx_d     = 10'(H_START);
                    rdir_d   = 1'b0;
                    timer_d  = '0;
                    state_d  = ST_MARCH;
                end
                ST_MARCH: begin
                    ew_act_d = ew_act_q & ~kills_w;
                    score_d  = kill_points(kills_w, kill_r);
                    if (kill_r) begin
                        er_act_d = 1'b0;
                        timer_d  = 7'(RESPAWN);
                    end
                    if (move) begin
                        // An edge bounce drops the formation instead of stepping it.
                        if (!dir_q) begin
                            if ({1'b0, fx_q} + FORM_SPAN_11 + {7'b0, step} > H_END_11) begin
                                dir_d = 1'b1;
                                fy_d  = fy_q + 10'(DROP);
                            end else begin
                                fx_d = fx_q + {6'b0, step};
                            end
                        end else begin
                            if ({1'b0, fx_q} - {7'b0, step} < H_START_11) begin
                                dir_d = 1'b0;
                                fy_d  = fy_q + 10'(DROP);
                            end else begin
                                fx_d = fx_q - {6'b0, step};
                            end
                        end

                        if (!er_act_q) begin
                            if (timer_q <= 7'd1) begin
                                er_act_d = 1'b1;
                                rx_d     = 10'(H_START);
                                rdir_d   = 1'b0;
                                timer_d  = '0;
                            end else begin
                                timer_d = timer_q - 7'd1;
                            end
                        end else if (!kill_r) begin
                            if (!rdir_q) begin
                                if ({1'b0, rx_q} + {6'b0, rstep} > R_MAX_11) rdir_d = 1'b1;
                                else rx_d = rx_q + {5'b0, rstep};
                            end else begin
                                if ({1'b0, rx_q} - {6'b0, rstep} < H_START_11) rdir_d = 1'b0;
                                else rx_d = rx_q - {5'b0, rstep};
                            end
                        end
                    end

                    // Killing the last white enemy outranks a simultaneous breach.
                    if (ew_act_d == '0) begin
                        state_d = ST_CLEARED;
                        clear_d = 1'b1;
                        if (wave_q != 3'd7) wave_d = wave_q + 3'd1;
                    end else if ({1'b0, fy_d} + W_SIZE_11 >= BREACH_Y_11) begin
                        state_d  = ST_HALT;
                        breach_d = 1'b1;
                    end
                end
                ST_CLEARED: begin
                    if (frame_tick) state_d = ST_SPAWN;
                end
                ST_HALT: begin
                    if (game_start_on) state_d = ST_SPAWN;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_W; gi++) begin : g_white
            enemy_sprite_hit u_white_hit (
                .x_i      (x),
                .y_i      (y),
                .pos_x_i  ({1'b0, fx_q} + 11'(gi * SPACING)),
                .pos_y_i  ({1'b0, fy_q}),
                .size_i   (6'(W_SIZE)),
                .active_i (ew_act_q[gi]),
                .on_o     (e_w_on[gi])
            );
        end
    endgenerate

    enemy_sprite_hit u_red_hit (
        .x_i      (x),
        .y_i      (y),
        .pos_x_i  ({1'b0, rx_q}),
        .pos_y_i  (11'(R_Y)),
        .size_i   (6'(R_SIZE)),
        .active_i (er_act_q),
        .on_o     (e_r_on)
    );

    assign rgb = e_r_on    ? RGB_RED   :
                 (|e_w_on) ? RGB_WHITE : RGB_BLACK;

    assign e_w_active  = ew_act_q;
    assign e_r_active  = er_act_q;
    assign score_pulse = score_q;
    assign wave_clear  = clear_q;
    assign breach      = breach_q;
    assign wave_num    = wave_q;

endmodule
